// File: rtl/serial_adder_if.sv
// Handshake and operand bus for the digit-serial adder.
// The master issues start/operands; the slave returns status and result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start,
    output a,
    output b,
    output cin,
    output sub,
    input  busy,
    input  done,
    input  sum,
    input  cout,
    input  overflow
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    input  cin,
    input  sub,
    output busy,
    output done,
    output sum,
    output cout,
    output overflow
  );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, LSB first,
// with carry, borrow and signed-overflow flags.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic          clk,
  input  logic          reset,
  serial_adder_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic             done_q;
  logic [CW-1:0]    cnt_q;

  logic [DIGIT-1:0] dsum_d;
  logic             dcarry_d;
  logic             cmsb_d;
  logic             last_d;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;

  always_comb begin
    {dcarry_d, dsum_d} = {1'b0, a_q[DIGIT-1:0]}
                       + {1'b0, b_q[DIGIT-1:0]}
                       + {{DIGIT{1'b0}}, carry_q};
    // carry into the digit MSB, recovered from its sum bit
    cmsb_d = dsum_d[DIGIT-1]
           ^ a_q[DIGIT-1]
           ^ b_q[DIGIT-1];
    res_d  = WIDTH'({dsum_d, res_q} >> DIGIT);
    a_d    = a_q >> DIGIT;
    b_d    = b_q >> DIGIT;
    last_d = (cnt_q == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub | bus.cin;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_d;
          b_q     <= b_d;
          res_q   <= res_d;
          carry_q <= dcarry_d;
          cnt_q   <= cnt_q + 1'b1;
          if (last_d) begin
            sum_q   <= res_d;
            cout_q  <= dcarry_d;
            ovf_q   <= cmsb_d ^ dcarry_d;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: four instances (DIGIT 1,2,4,8) checked
// against a queued scoreboard for result, flags and latency.
module tb_serial_adder;
  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] start_v = '0;
  logic [7:0] a_v = '0;
  logic [7:0] b_v = '0;
  logic       cin_v = 1'b0;
  logic       sub_v = 1'b0;

  logic       busy_w [4];
  logic       done_w [4];
  logic       cout_w [4];
  logic       ovf_w  [4];
  logic [7:0] sum_w  [4];

  exp_t q [4][$];
  int   done_cnt [4];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    serial_adder_if #(.WIDTH(8)) bus ();
    assign bus.start  = start_v[g];
    assign bus.a      = a_v;
    assign bus.b      = b_v;
    assign bus.cin    = cin_v;
    assign bus.sub    = sub_v;
    assign busy_w[g]  = bus.busy;
    assign done_w[g]  = bus.done;
    assign sum_w[g]   = bus.sum;
    assign cout_w[g]  = bus.cout;
    assign ovf_w[g]   = bus.overflow;
    serial_adder #(
      .WIDTH(8),
      .DIGIT(1 << g)
    ) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
    );
  end

  task automatic chk(input string tag, input int g,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d: observed=%0h expected=%0h",
             tag, g, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, b,
                                 input logic c, s);
    logic [7:0] bb;
    logic [8:0] full;
    exp_t       e;
    bb     = s ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + {8'd0, (s ? 1'b1 : c)};
    e.sum  = full[7:0];
    e.cout = full[8];
    e.ovf  = (a[7] == bb[7]) && (full[7] != a[7]);
    e.cyc  = 0;
    return e;
  endfunction

  // scoreboard consumer
  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < 4; g++) begin
      if (!reset && done_w[g]) begin
        done_cnt[g]++;
        chk("done_expected", g, q[g].size() != 0, 1);
        chk("busy_at_done", g, busy_w[g], 0);
        if (q[g].size() != 0) begin
          e = q[g].pop_front();
          chk("sum", g, sum_w[g], e.sum);
          chk("cout", g, cout_w[g], e.cout);
          chk("overflow", g, ovf_w[g], e.ovf);
          chk("latency", g, cyc, e.cyc);
        end
      end
    end
  end

  task automatic issue(input int g, input logic [7:0] a, b,
                       input logic c, s, input logic [7:0] xs,
                       input logic xc, xo);
    exp_t e;
    a_v        = a;
    b_v        = b;
    cin_v      = c;
    sub_v      = s;
    start_v[g] = 1'b1;
    @(posedge clk);
    #1;
    e.sum  = xs;
    e.cout = xc;
    e.ovf  = xo;
    e.cyc  = cyc + (8 >> g);
    q[g].push_back(e);
    start_v[g] = 1'b0;
    a_v   = 8'($urandom);
    b_v   = 8'($urandom);
    cin_v = 1'($urandom);
    sub_v = 1'($urandom);
  endtask

  task automatic wait_done(input int g);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_w[g] && n < 20);
    chk("done_timeout", g, done_w[g], 1);
  endtask

  initial begin
    exp_t e;
    int   cnt0;
    for (int g = 0; g < 4; g++) done_cnt[g] = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      chk("rst_busy", g, busy_w[g], 0);
      chk("rst_done", g, done_w[g], 0);
      chk("rst_sum", g, sum_w[g], 0);
      chk("rst_cout", g, cout_w[g], 0);
      chk("rst_ovf", g, ovf_w[g], 0);
    end
    reset = 1'b0;
    @(negedge clk);

    issue(0, 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
    @(negedge clk);
    chk("run_busy", 0, busy_w[0], 1);
    chk("run_sum_hold", 0, sum_w[0], 8'h00);
    @(negedge clk);
    a_v        = 8'h01;
    b_v        = 8'h01;
    cin_v      = 1'b0;
    sub_v      = 1'b0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    chk("ignored_busy", 0, busy_w[0], 1);
    chk("ignored_done", 0, done_w[0], 0);
    wait_done(0);
    issue(0, 8'h02, 8'h03, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b_busy", 0, busy_w[0], 1);
    chk("b2b_sum_hold", 0, sum_w[0], 8'h96);
    chk("b2b_ovf_hold", 0, ovf_w[0], 1);
    wait_done(0);

    issue(0, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
    wait_done(0);
    issue(0, 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
    wait_done(0);
    issue(0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    wait_done(0);

    for (int g = 1; g < 4; g++) begin
      @(negedge clk);
      issue(g, 8'h99, 8'h77, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0);
      wait_done(g);
    end

    // abandon an operation with reset in its 4th RUN cycle
    @(negedge clk);
    a_v        = 8'h33;
    b_v        = 8'h44;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 0, busy_w[0], 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", 0, busy_w[0], 0);
    chk("midrst_done", 0, done_w[0], 0);
    chk("midrst_sum", 0, sum_w[0], 0);
    chk("midrst_cout", 0, cout_w[0], 0);
    chk("midrst_ovf", 0, ovf_w[0], 0);
    cnt0 = done_cnt[0];
    repeat (12) @(negedge clk);
    chk("no_done_after_rst", 0, done_cnt[0], cnt0);
    issue(0, 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
    wait_done(0);

    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      for (int k = 0; k < 250; k++) begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic       rs;
        ra = 8'($urandom);
        rb = 8'($urandom);
        rc = 1'($urandom);
        rs = 1'($urandom);
        e  = model(ra, rb, rc, rs);
        issue(g, ra, rb, rc, rs, e.sum, e.cout, e.ovf);
        wait_done(g);
        if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    for (int g = 0; g < 4; g++)
      chk("queue_empty", g, q[g].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
